// File: rtl/sw_poll_pkg.sv
// Shared FSM state type, CSR addresses and register bit positions for sw_poll_ctrl.
package sw_poll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_EVAL = 2'd3
    } poll_state_e;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_STABLE = 2'd2;
    localparam logic [1:0] CSR_EVENT  = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_EMPTY_BIT  = 8;
    localparam int STAT_FULL_BIT   = 9;
    localparam int STAT_OVF_BIT    = 10;
    localparam int STAT_MISS_BIT   = 11;
    localparam int EVT_VALID_BIT   = 31;
    localparam int EVT_MASK_LSB    = 16;

endpackage

// File: rtl/sw_event_fifo.sv
// Synchronous show-ahead FIFO holding switch change events; o_data is the head entry.
module sw_event_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign w_do_pop = i_pop && !o_empty;
    // When full, a push lands in the slot the simultaneous pop is vacating.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sw_poll_ctrl.sv
// Polls a switch PIO, debounces the value and queues change events for a CPU.
// Optional level interrupt is built when SW_POLL_IRQ_EN is defined.
module sw_poll_ctrl
    import sw_poll_pkg::*;
#(
    parameter int SW_W       = 10,
    parameter int POLL_DIV   = 50000,
    parameter int STABLE_CNT = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [1:0]      pio_address,
    output logic            pio_read,
    input  logic [31:0]     pio_readdata,
    input  logic [1:0]      csr_address,
    input  logic            csr_read,
    input  logic            csr_write,
    input  logic [31:0]     csr_writedata,
    output logic [31:0]     csr_readdata,
    output logic [SW_W-1:0] sw_stable,
    output logic [1:0]      o_dbg_state
`ifdef SW_POLL_IRQ_EN
    ,
    output logic            irq
`endif
);

    localparam int PRESC_W = $clog2(POLL_DIV);
    localparam int CNT_W   = $clog2(STABLE_CNT + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(POLL_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(STABLE_CNT);

    poll_state_e        r_state;
    logic [PRESC_W-1:0] r_presc;
    logic               r_en;
    logic               r_ovf;
    logic               r_miss;
    logic               r_pio_read;
    logic [SW_W-1:0]    r_sample;
    logic [SW_W-1:0]    r_cand;
    logic [SW_W-1:0]    r_sw_stable;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_csr_readdata;
`ifdef SW_POLL_IRQ_EN
    logic               r_irq_en;
    logic               r_irq;
`endif

    logic               w_tick;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_accept;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic               w_ovf_set;
    logic               w_miss_set;
    logic               w_status_wr;
    logic [2*SW_W-1:0]  w_head;
    logic [FCNT_W-1:0]  w_fifo_count;
    logic [31:0]        w_ctrl_word;
    logic [31:0]        w_status_word;
    logic [31:0]        w_event_word;
    logic               w_unused;

    // Strobes: pio_read is a one-cycle pulse and pio_readdata is taken the following cycle;
    // csr_read/csr_write are single-cycle with no wait states, csr_readdata follows one cycle later.
    assign pio_address  = 2'b00;
    assign pio_read     = r_pio_read;
    assign csr_readdata = r_csr_readdata;
    assign sw_stable    = r_sw_stable;
    assign o_dbg_state  = r_state;
    assign w_unused     = ^{pio_readdata, csr_writedata};

    assign w_tick      = r_en && (r_presc == PRESC_LAST);
    assign w_miss_set  = w_tick && (r_state != ST_IDLE);
    assign w_pop       = csr_read && (csr_address == CSR_EVENT) && !w_empty;
    assign w_ovf_set   = w_accept && w_full && !w_pop;
    assign w_status_wr = csr_write && (csr_address == CSR_STATUS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (!r_en || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // A new value must be seen STABLE_CNT polls in a row before it replaces sw_stable.
    always_comb begin
        w_cnt_next = CNT_W'(1);
        if (r_sample == r_cand) begin
            w_cnt_next = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
        end
        w_accept = (r_state == ST_EVAL) && (w_cnt_next == CNT_SAT) && (r_sample != r_sw_stable);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_pio_read  <= 1'b0;
            r_sample    <= '0;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_sw_stable <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state    <= ST_RD;
                        r_pio_read <= 1'b1;
                    end
                end
                ST_RD: begin
                    r_state    <= ST_CAP;
                    r_pio_read <= 1'b0;
                end
                ST_CAP: begin
                    r_state  <= ST_EVAL;
                    r_sample <= pio_readdata[SW_W-1:0];
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cand  <= r_sample;
                    r_cnt   <= w_cnt_next;
                    if (w_accept) begin
                        r_sw_stable <= r_sample;
                    end
                end
            endcase
        end
    end

    sw_event_fifo #(
        .WIDTH (2 * SW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_data  ({r_sample ^ r_sw_stable, r_sample}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_comb begin
        w_ctrl_word = '0;
        w_ctrl_word[CTRL_EN_BIT] = r_en;
`ifdef SW_POLL_IRQ_EN
        w_ctrl_word[CTRL_IRQ_EN_BIT] = r_irq_en;
`endif
        w_status_word = '0;
        w_status_word[4:0] = 5'(w_fifo_count);
        w_status_word[STAT_EMPTY_BIT] = w_empty;
        w_status_word[STAT_FULL_BIT]  = w_full;
        w_status_word[STAT_OVF_BIT]   = r_ovf;
        w_status_word[STAT_MISS_BIT]  = r_miss;
        w_event_word = '0;
        if (!w_empty) begin
            w_event_word[EVT_VALID_BIT] = 1'b1;
            w_event_word[EVT_MASK_LSB +: SW_W] = w_head[2*SW_W-1:SW_W];
            w_event_word[SW_W-1:0] = w_head[SW_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en           <= 1'b0;
            r_ovf          <= 1'b0;
            r_miss         <= 1'b0;
            r_csr_readdata <= '0;
`ifdef SW_POLL_IRQ_EN
            r_irq_en       <= 1'b0;
`endif
        end else begin
            if (csr_write && (csr_address == CSR_CTRL)) begin
                r_en <= csr_writedata[CTRL_EN_BIT];
`ifdef SW_POLL_IRQ_EN
                r_irq_en <= csr_writedata[CTRL_IRQ_EN_BIT];
`endif
            end
            // Sticky flags: a set in the same cycle as a W1C clear wins.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_status_wr && csr_writedata[STAT_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
            if (w_miss_set) begin
                r_miss <= 1'b1;
            end else if (w_status_wr && csr_writedata[STAT_MISS_BIT]) begin
                r_miss <= 1'b0;
            end
            if (csr_read) begin
                case (csr_address)
                    CSR_CTRL:   r_csr_readdata <= w_ctrl_word;
                    CSR_STATUS: r_csr_readdata <= w_status_word;
                    CSR_STABLE: r_csr_readdata <= 32'(r_sw_stable);
                    default:    r_csr_readdata <= w_event_word;
                endcase
            end
        end
    end

`ifdef SW_POLL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en && (!w_empty || r_ovf);
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_sw_poll_ctrl.sv
// Directed bench for sw_poll_ctrl with POLL_DIV=8, STABLE_CNT=3, FIFO_DEPTH=4, SW_W=10.
// Covers the irq path as well when built with SW_POLL_IRQ_EN.
module tb_sw_poll_ctrl;

    localparam int SW_W       = 10;
    localparam int POLL_DIV   = 8;
    localparam int STABLE_CNT = 3;
    localparam int FIFO_DEPTH = 4;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_STABLE = 2'd2;
    localparam logic [1:0] A_EVENT  = 2'd3;

    typedef struct {
        logic [SW_W-1:0] sw;
        int              polls;
        logic [SW_W-1:0] exp_stable;
        logic [31:0]     exp_status;
        bit              do_evt;
        logic [31:0]     exp_evt;
    } step_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      pio_address;
    logic            pio_read;
    logic [31:0]     pio_readdata = 32'hFFFF_FFFF;
    logic [1:0]      csr_address = 2'd0;
    logic            csr_read = 1'b0;
    logic            csr_write = 1'b0;
    logic [31:0]     csr_writedata = 32'd0;
    logic [31:0]     csr_readdata;
    logic [SW_W-1:0] sw_stable;
    logic [1:0]      dbg_state;
`ifdef SW_POLL_IRQ_EN
    logic            irq;
`endif

    logic [SW_W-1:0] sw = '0;
    logic [SW_W-1:0] cap_sw = '0;
    logic            rd_prev = 1'b0;
    int              n_checks = 0;
    int              n_pass = 0;
    logic [31:0]     exp_q[$];
    step_t           steps[11];

    sw_poll_ctrl #(
        .SW_W       (SW_W),
        .POLL_DIV   (POLL_DIV),
        .STABLE_CNT (STABLE_CNT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pio_address   (pio_address),
        .pio_read      (pio_read),
        .pio_readdata  (pio_readdata),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .sw_stable     (sw_stable),
        .o_dbg_state   (dbg_state)
`ifdef SW_POLL_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Switch PIO model: data is valid only in the cycle after pio_read, garbage otherwise.
    always @(negedge clk) begin
        if (rd_prev) pio_readdata = {{(32-SW_W){1'b0}}, cap_sw};
        else         pio_readdata = 32'hFFFF_FFFF;
        rd_prev = pio_read;
        if (pio_read) cap_sw = sw;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        csr_address = a;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read    = 1'b0;
        d = csr_readdata;
    endtask

    task automatic set_sw(input logic [SW_W-1:0] v);
        @(posedge clk);
        #2;
        sw = v;
    endtask

    // Returns at the falling edge inside the RD cycle; cycles = falling edges waited.
    task automatic wait_rd(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!pio_read && cycles < 64);
        if (!pio_read) begin
            n_checks++;
            $display("FAIL wait_rd: no pio_read within 64 cycles");
        end
    endtask

    // Returns in the IDLE cycle right after the n-th counted poll has been evaluated.
    task automatic wait_polls(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            wait_rd(c);
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0]     rd;
        int              cyc;
        int              pulses;
        logic [SW_W-1:0] exp_stable_final;

        steps[0]  = '{10'h005, 2, 10'h000, 32'h0000_0100, 1'b0, 32'h0};
        steps[1]  = '{10'h005, 1, 10'h005, 32'h0000_0100, 1'b1, 32'h8005_0005};
        steps[2]  = '{10'h004, 1, 10'h005, 32'h0000_0100, 1'b0, 32'h0};
        steps[3]  = '{10'h005, 1, 10'h005, 32'h0000_0100, 1'b0, 32'h0};
        steps[4]  = '{10'h004, 1, 10'h005, 32'h0000_0100, 1'b0, 32'h0};
        steps[5]  = '{10'h005, 1, 10'h005, 32'h0000_0100, 1'b0, 32'h0};
        steps[6]  = '{10'h0AA, 3, 10'h0AA, 32'h0000_0001, 1'b0, 32'h0};
        steps[7]  = '{10'h155, 3, 10'h155, 32'h0000_0002, 1'b0, 32'h0};
        steps[8]  = '{10'h3FF, 3, 10'h3FF, 32'h0000_0003, 1'b0, 32'h0};
        steps[9]  = '{10'h001, 3, 10'h001, 32'h0000_0204, 1'b0, 32'h0};
        steps[10] = '{10'h200, 3, 10'h200, 32'h0000_0604, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_pio_read", 32'(pio_read), 32'h0);
        check("reset_pio_address", 32'(pio_address), 32'h0);
        check("reset_csr_readdata", csr_readdata, 32'h0);
        check("reset_sw_stable", 32'(sw_stable), 32'h0);
`ifdef SW_POLL_IRQ_EN
        check("reset_irq", 32'(irq), 32'h0);
`endif
        reset_n = 1'b1;
        csr_rd(A_STATUS, rd); check("reset_status", rd, 32'h0000_0100);
        csr_rd(A_CTRL, rd);   check("reset_ctrl", rd, 32'h0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (pio_read) pulses++;
        end
        check("no_poll_while_disabled", 32'(pulses), 32'd0);

        // Enable: first poll 8 cycles after the write, then every 8 cycles
        csr_wr(A_CTRL, 32'h1);
        wait_rd(cyc); check("first_poll_latency", 32'(cyc), 32'd8);
        wait_rd(cyc); check("poll_period", 32'(cyc), 32'd8);
        csr_rd(A_CTRL, rd); check("ctrl_en", rd, 32'h1);

        // Debounce / event table
        for (int i = 0; i < 11; i++) begin
            set_sw(steps[i].sw);
            wait_polls(steps[i].polls);
            check($sformatf("step%0d_stable", i), 32'(sw_stable), 32'(steps[i].exp_stable));
            if (steps[i].do_evt) begin
                csr_rd(A_EVENT, rd);
                check($sformatf("step%0d_event", i), rd, steps[i].exp_evt);
            end
            csr_rd(A_STATUS, rd);
            check($sformatf("step%0d_status", i), rd, steps[i].exp_status);
        end

        // W1C on OVF, writes to read-only registers ignored
        csr_wr(A_STATUS, 32'h0000_0400);
        csr_rd(A_STATUS, rd); check("ovf_w1c", rd, 32'h0000_0204);
        csr_wr(A_STABLE, 32'h0000_03FF);
        csr_rd(A_STABLE, rd); check("stable_ro", rd, 32'h0000_0200);
        csr_wr(A_STATUS, 32'h0000_000F);
        csr_rd(A_STATUS, rd); check("status_count_ro", rd, 32'h0000_0204);

        // EVENT read in the same cycle as a push into a full FIFO
        set_sw(10'h0F0);
        wait_polls(2);
        wait_rd(cyc);
        @(negedge clk);
        csr_rd(A_EVENT, rd); check("push_pop_full_event", rd, 32'h80AF_00AA);
        check("push_pop_full_stable", 32'(sw_stable), 32'h0F0);
        csr_rd(A_STATUS, rd); check("push_pop_full_status", rd, 32'h0000_0204);

        // Drain the FIFO through the scoreboard
        exp_q.push_back(32'h81FF_0155);
        exp_q.push_back(32'h82AA_03FF);
        exp_q.push_back(32'h83FE_0001);
        exp_q.push_back(32'h82F0_00F0);
        while (exp_q.size() > 0) begin
            csr_rd(A_EVENT, rd);
            check("drain_event", rd, exp_q.pop_front());
        end
        csr_rd(A_STATUS, rd); check("drained_status", rd, 32'h0000_0100);
        csr_rd(A_EVENT, rd);  check("empty_event_read", rd, 32'h0);
        csr_rd(A_STATUS, rd); check("empty_read_status", rd, 32'h0000_0100);

        // Clearing EN during CAP lets the in-flight poll finish, then polling stops
        set_sw(10'h111);
        wait_polls(2);
        wait_rd(cyc);
        csr_wr(A_CTRL, 32'h0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (pio_read) pulses++;
        end
        check("no_poll_after_disable", 32'(pulses), 32'd0);
        check("inflight_poll_stable", 32'(sw_stable), 32'h111);
        csr_rd(A_EVENT, rd);  check("inflight_poll_event", rd, 32'h81E1_0111);
        csr_rd(A_CTRL, rd);   check("ctrl_cleared", rd, 32'h0);

        // Re-enable with IRQ_EN requested
        csr_wr(A_CTRL, 32'h3);
        wait_rd(cyc); check("reenable_latency", 32'(cyc), 32'd8);
        csr_rd(A_CTRL, rd);
`ifdef SW_POLL_IRQ_EN
        check("ctrl_irq_en", rd, 32'h3);
        check("irq_idle", 32'(irq), 32'h0);
        set_sw(10'h00F);
        wait_polls(3);
        @(negedge clk);
        check("irq_on_event", 32'(irq), 32'h1);
        csr_rd(A_EVENT, rd); check("irq_event", rd, 32'h811E_000F);
        @(negedge clk);
        check("irq_after_drain", 32'(irq), 32'h0);
        set_sw(10'h0F0);
        wait_polls(3);
        @(negedge clk);
        check("irq_second_event", 32'(irq), 32'h1);
        exp_stable_final = 10'h0F0;
`else
        check("ctrl_irq_bit_absent", rd, 32'h1);
        exp_stable_final = 10'h111;
`endif

        // Asynchronous reset in the middle of CAP
        csr_rd(A_STABLE, rd); check("stable_before_reset", rd, 32'(exp_stable_final));
        wait_rd(cyc);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_pio_read", 32'(pio_read), 32'h0);
        check("async_csr_readdata", csr_readdata, 32'h0);
        check("async_sw_stable", 32'(sw_stable), 32'h0);
        check("async_pio_address", 32'(pio_address), 32'h0);
`ifdef SW_POLL_IRQ_EN
        check("async_irq", 32'(irq), 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        csr_rd(A_STATUS, rd); check("post_reset_status", rd, 32'h0000_0100);
        csr_rd(A_CTRL, rd);   check("post_reset_ctrl", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sw_poll_ctrl.md
SW_POLL_CTRL -- requirements
Module: sw_poll_ctrl

Interface
REQ-001 Parameter SW_W, default 10, switch vector width (1..16).
REQ-002 Parameter POLL_DIV, default 50000, clk cycles between polls (>=8).
REQ-003 Parameter STABLE_CNT, default 4, consecutive equal samples required to accept a value (>=1).
REQ-004 Parameter FIFO_DEPTH, default 8, change-event FIFO entries (power of 2, 2..16).
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 pio_address  out  2  switch PIO word address, constant 0.
REQ-008 pio_read  out  1  switch PIO read strobe, one-cycle pulse.
REQ-009 pio_readdata  in  32  switch PIO data, valid the cycle after pio_read.
REQ-010 csr_address  in  2  CPU register select.
REQ-011 csr_read / csr_write  in  1  CPU strobes; zero wait states.
REQ-012 csr_writedata  in  32  CPU write data.
REQ-013 csr_readdata  out  32  CPU read data, registered, valid the cycle after csr_read.
REQ-014 sw_stable  out  SW_W  current debounced switch value.
REQ-015 irq  out  1  level interrupt; present only when SW_POLL_IRQ_EN is defined.

Function
REQ-016 Prescaler SHALL count 0..POLL_DIV-1 while CTRL.EN=1, emit a one-cycle tick at POLL_DIV-1, and hold at 0 while EN=0.
REQ-017 FSM SHALL have states IDLE, RD, CAP, EVAL: IDLE->RD on tick; RD drives pio_read=1 for exactly one cycle -> CAP; CAP latches pio_readdata[SW_W-1:0] -> EVAL; EVAL updates debounce -> IDLE.
REQ-018 A tick arriving while FSM is not IDLE SHALL be dropped and set sticky STATUS.MISS.
REQ-019 Debounce in EVAL: sample==candidate -> cnt increments, saturating at STABLE_CNT; else candidate<=sample, cnt<=1.
REQ-020 When cnt reaches STABLE_CNT and candidate!=sw_stable, sw_stable SHALL take candidate in the same cycle and one event {mask=old^new, value=new} SHALL be pushed.
REQ-021 FIFO full on push: event dropped, sticky STATUS.OVF set, sw_stable still updated.
REQ-022 CSR 0 CTRL R/W: bit0 EN, bit1 IRQ_EN; other bits read 0.
REQ-023 CSR 1 STATUS: [4:0] FIFO count, bit8 EMPTY, bit9 FULL, bit10 OVF, bit11 MISS; write 1 to bit10/bit11 clears it (W1C); set on the same cycle as a clear wins.
REQ-024 CSR 2 STABLE R: zero-extended sw_stable.
REQ-025 CSR 3 EVENT R: bit31 valid, [16+SW_W-1:16] mask, [SW_W-1:0] value; a read pops one entry; a read when empty returns 0 and pops nothing.
REQ-026 Simultaneous push and pop SHALL both take effect, count unchanged, no OVF even when full.
REQ-027 Writes to read-only CSRs SHALL be ignored.
REQ-028 Clearing EN mid-poll SHALL let the in-flight RD/CAP/EVAL sequence complete; no further ticks.

Reset
REQ-029 On reset_n low: pio_read=0, pio_address=0, csr_readdata=0, sw_stable=0, irq=0, candidate=0, cnt=0, CTRL=0, OVF=MISS=0, FIFO empty, prescaler 0, FSM IDLE.

Configuration
REQ-030 SW_POLL_IRQ_EN defined: irq = IRQ_EN & (!EMPTY | OVF), registered; absent: irq port, IRQ_EN storage and logic removed, CTRL bit1 reads 0.

Structure
REQ-031 Package sw_poll_pkg SHALL hold the FSM state enum, CSR address constants and STATUS/CTRL bit positions.
REQ-032 FIFO SHALL be sub-module sw_event_fifo (synchronous, show-ahead, count output).

Verification (POLL_DIV=8, STABLE_CNT=3, FIFO_DEPTH=4)
REQ-033 Reset, then CTRL=1, switches 0x005 steady -> pio_read every 8 cycles; after 3rd sample sw_stable=0x005, EVENT read = 0x8005_0005.
REQ-034 Switches toggle 0x005/0x004 every poll -> sw_stable stays 0x005, FIFO stays empty.
REQ-035 Five accepted changes without reads -> count=4, FULL=1, OVF=1; sw_stable equals 5th value; W1C 0x400 clears OVF.
REQ-036 EVENT read same cycle as push with FIFO full -> count stays 4, OVF stays 0.
REQ-037 EVENT read when empty -> csr_readdata=0x0000_0000, count stays 0.
REQ-038 SW_POLL_IRQ_EN with CTRL=3: first event -> irq=1; draining FIFO -> irq=0; reset_n low mid-CAP -> all outputs 0 asynchronously.
